instr_fetch_sequencer: RTL and testbench

//  Sequences the 64-entry x 32-bit instruction memory: owns the PC and drives the memory address.

---
 rtl/instr_fetch_sequencer_if.sv | 26 ++
 rtl/instr_fetch_sequencer.sv | 135 +++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_sequencer_if.sv
// instr_fetch_sequencer_if
// Instruction delivery handshake between the fetch sequencer and the
// decode/controller stage. The sequencer drives the master side.
interface instr_fetch_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer
// Owns the PC for a 64 x 32 instruction memory with combinational read,
// captures each fetched word into a one-deep output buffer and hands it to
// the controller over a valid/ready handshake. Supports start, branch
// redirect, backpressure and halt.
//
// Optional feature macro: HALT_ON_ZERO_EN
//   defined   - an all-zero word stops fetching (HALT) instead of loading.
//   undefined - zero words are ordinary instructions; halted is tied low.
module instr_fetch_sequencer #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int START_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_data,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_addr,
    instr_fetch_sequencer_if.master    instr_if,
    output logic                       busy,
    output logic                       halted
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;

    logic              load;
    logic              accept;
    logic              halt_on_zero;
    logic [ADDR_W-1:0] pc_inc;

    // The buffer can take a new word when it is empty or being drained this cycle.
    assign load   = !valid_q || instr_if.instr_ready;
    assign accept = valid_q && instr_if.instr_ready;
    assign pc_inc = pc_q + 1'b1;

`ifdef HALT_ON_ZERO_EN
    assign halt_on_zero = (imem_data == '0);
`else
    assign halt_on_zero = 1'b0;
`endif

    // Next-state logic: sequencing, redirect flush, load/stall and halt handling.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        data_d  = data_q;
        ipc_d   = ipc_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = START_PC;
                end
            end

            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_d    = redirect_addr;
                    valid_d = 1'b0;
                end else if (load) begin
                    if (halt_on_zero) begin
                        state_d = ST_HALT;
                        valid_d = 1'b0;
                    end else begin
                        data_d  = imem_data;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end
                end
            end

            ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = START_PC;
                    valid_d = 1'b0;
                end else if (accept) begin
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                pc_d    = START_PC;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that discards any buffered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= START_PC;
            valid_q <= 1'b0;
            data_q  <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ipc_q   <= ipc_d;
        end
    end

    assign imem_addr            = pc_q;
    assign instr_if.instr_valid = valid_q;
    assign instr_if.instr_data  = data_q;
    assign instr_if.instr_pc    = ipc_q;
    assign busy                 = (state_q == ST_FETCH);

`ifdef HALT_ON_ZERO_EN
    assign halted = (state_q == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer
// Directed bench for instr_fetch_sequencer with a behavioural reference model
// checked every cycle plus hand-computed literal expectations.
// Honours HALT_ON_ZERO_EN when the same macro is defined for the build.
module tb_instr_fetch_sequencer;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;

`ifdef HALT_ON_ZERO_EN
    localparam bit HALT_ZERO = 1'b1;
`else
    localparam bit HALT_ZERO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_addr = '0;
    logic              busy;
    logic              halted;

    logic [DATA_W-1:0] mem [DEPTH];

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    // Reference model state
    bit          m_live    = 1'b0;
    bit          m_running = 1'b0;
    bit          m_halted  = 1'b0;
    int          m_pc      = 0;
    bit          m_valid   = 1'b0;
    logic [31:0] m_data    = '0;
    int          m_ipc     = 0;

    instr_fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    instr_fetch_sequencer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .START_ADDR(0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .instr_if      (ifc),
        .busy          (busy),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs, let the rising edge happen, then settle.
    task automatic applyStimulus(input logic r, input logic s, input logic rv,
                                 input logic [ADDR_W-1:0] ra, input logic rdy);
        rst              = r;
        start            = s;
        redirect_valid   = rv;
        redirect_addr    = ra;
        ifc.instr_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    // Step with ready high until the buffer shows the given PC, bounded.
    task automatic waitPc(input int target);
        int n = 0;
        while (!(ifc.instr_valid === 1'b1 && int'(ifc.instr_pc) == target) && n < 200) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
            n++;
        end
        checkOutput("waitPc.valid", 32'(ifc.instr_valid), 32'd1);
        checkOutput("waitPc.pc", 32'(ifc.instr_pc), 32'(target));
    endtask

    // Reference model: what the outputs must be after each rising edge.
    always @(posedge clk) begin
        logic [31:0] word;
        if (rst) begin
            m_live = 1'b1; m_running = 1'b0; m_halted = 1'b0;
            m_pc = 0; m_valid = 1'b0; m_data = '0; m_ipc = 0;
        end else if (m_running) begin
            if (redirect_valid) begin
                m_pc    = int'(redirect_addr);
                m_valid = 1'b0;
            end else if (!m_valid || ifc.instr_ready) begin
                word = mem[m_pc];
                if (HALT_ZERO && word == 32'h0) begin
                    m_running = 1'b0; m_halted = 1'b1; m_valid = 1'b0;
                end else begin
                    m_data = word; m_ipc = m_pc; m_valid = 1'b1;
                    m_pc = (m_pc + 1) % DEPTH;
                end
            end
        end else if (m_halted) begin
            if (start) begin
                m_halted = 1'b0; m_running = 1'b1; m_pc = 0; m_valid = 1'b0;
            end else if (m_valid && ifc.instr_ready) begin
                m_valid = 1'b0;
            end
        end else if (start) begin
            m_running = 1'b1; m_pc = 0;
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live && !done) begin
            checkOutput("model.imem_addr", 32'(imem_addr), 32'(m_pc));
            checkOutput("model.valid", 32'(ifc.instr_valid), 32'(m_valid));
            checkOutput("model.busy", 32'(busy), 32'(m_running));
            checkOutput("model.halted", 32'(halted), 32'(m_halted));
            if (m_valid) begin
                checkOutput("model.instr_data", ifc.instr_data, m_data);
                checkOutput("model.instr_pc", 32'(ifc.instr_pc), 32'(m_ipc));
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE_0100 | 32'(i);
        mem[22] = 32'h0;
        ifc.instr_ready = 1'b1;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("rst.valid", 32'(ifc.instr_valid), 32'd0);
        checkOutput("rst.imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.halted", 32'(halted), 32'd0);
        checkOutput("rst.instr_pc", 32'(ifc.instr_pc), 32'd0);
        checkOutput("rst.instr_data", ifc.instr_data, 32'd0);

        // Redirect ignored in IDLE
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd20, 1'b1);
        checkOutput("idle_redir.imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("idle_redir.busy", 32'(busy), 32'd0);

        // Start and first-word latency
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        checkOutput("start.busy", 32'(busy), 32'd1);
        checkOutput("start.valid", 32'(ifc.instr_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("first.valid", 32'(ifc.instr_valid), 32'd1);
        checkOutput("first.pc", 32'(ifc.instr_pc), 32'd0);
        checkOutput("first.data", ifc.instr_data, 32'hC0DE_0100);
        checkOutput("first.imem_addr", 32'(imem_addr), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("stream.pc3", 32'(ifc.instr_pc), 32'd3);

        // Backpressure at instr_pc=4
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
            checkOutput("stall.pc", 32'(ifc.instr_pc), 32'd4);
            checkOutput("stall.data", ifc.instr_data, 32'hC0DE_0104);
            checkOutput("stall.imem_addr", 32'(imem_addr), 32'd5);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("unstall.pc", 32'(ifc.instr_pc), 32'd5);

        // Redirect to 12 while instr_pc=7, ready high
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("pre_redir.pc", 32'(ifc.instr_pc), 32'd7);
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd12, 1'b1);
        checkOutput("redir.valid", 32'(ifc.instr_valid), 32'd0);
        checkOutput("redir.imem_addr", 32'(imem_addr), 32'd12);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("redir_tgt.pc", 32'(ifc.instr_pc), 32'd12);
        checkOutput("redir_tgt.data", ifc.instr_data, 32'hC0DE_010C);

        // Start with redirect in FETCH: redirect wins; then 63 -> 0 wrap
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd63, 1'b1);
        checkOutput("redir63.imem_addr", 32'(imem_addr), 32'd63);
        checkOutput("redir63.valid", 32'(ifc.instr_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("wrap.pc63", 32'(ifc.instr_pc), 32'd63);
        checkOutput("wrap.imem_addr", 32'(imem_addr), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("wrap.pc0", 32'(ifc.instr_pc), 32'd0);

        // Reset mid-operation at instr_pc=9
        waitPc(9);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("midrst.valid", 32'(ifc.instr_valid), 32'd0);
        checkOutput("midrst.pc", 32'(ifc.instr_pc), 32'd0);
        checkOutput("midrst.busy", 32'(busy), 32'd0);
        checkOutput("midrst.halted", 32'(halted), 32'd0);
        checkOutput("midrst.imem_addr", 32'(imem_addr), 32'd0);

        // Zero word at address 22
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        waitPc(21);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
`ifdef HALT_ON_ZERO_EN
        checkOutput("zero.halted", 32'(halted), 32'd1);
        checkOutput("zero.busy", 32'(busy), 32'd0);
        checkOutput("zero.valid", 32'(ifc.instr_valid), 32'd0);
        checkOutput("zero.imem_addr", 32'(imem_addr), 32'd22);
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd5, 1'b1);
        checkOutput("halt_hold.imem_addr", 32'(imem_addr), 32'd22);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        checkOutput("restart.busy", 32'(busy), 32'd1);
        checkOutput("restart.halted", 32'(halted), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("restart.valid", 32'(ifc.instr_valid), 32'd1);
        checkOutput("restart.pc", 32'(ifc.instr_pc), 32'd0);
`else
        checkOutput("zero.pc", 32'(ifc.instr_pc), 32'd22);
        checkOutput("zero.data", ifc.instr_data, 32'd0);
        checkOutput("zero.valid", 32'(ifc.instr_valid), 32'd1);
        checkOutput("zero.halted", 32'(halted), 32'd0);
        waitPc(63);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("zero_wrap.pc", 32'(ifc.instr_pc), 32'd0);
`endif

        @(negedge clk);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
